data_mem_split: RTL and testbench
=================================

# data_mem_split

Parametrised byte-addressable data memory with a req/gnt/rvalid handshake. It is the next generation of the bus-side data memory and supports any data width, any depth and misaligned accesses. A misaligned access that spans two word rows runs as two row beats under a small FSM. Out-of-range and disallowed-misaligned accesses return an error instead of wrapping or padding. It sits behind the bus decoder as the core's data RAM.

## Interface
- ADDR_W, 13: byte-address width; capacity DEPTH = 2**ADDR_W bytes.
- DATA_W, 32: data width in bits; power of two, ≥ 16. NB = DATA_W/8 lanes. Row count = DEPTH/NB.
- ALLOW_MISALIGNED, 1: 1 = split row-crossing accesses into two beats; 0 = flag them as errors.
- clk_i  in  1  single clock, all state updates on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_i  in  1  access request; sampled only when gnt_o = 1.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  NB  byte enables. Lane k addresses byte addr_i+k.
- addr_i  in  ADDR_W  byte start address; any alignment.
- wdata_i  in  DATA_W  lane k (bits 8k+7:8k) is written to byte addr_i+k.
- gnt_o  out  1  combinational; 1 iff FSM is IDLE.
- rvalid_o  out  1  one-cycle response strobe, for reads and writes.
- rdata_o  out  DATA_W  lane k = byte addr_i+k if be_i[k], else 0. Held until the next rvalid_o.
- err_o  out  1  valid with rvalid_o; 1 = access rejected.

## Operation
- Storage: rows of NB bytes, row = byte_addr / NB, lane = byte_addr % NB. Array contents are not reset.
- Accept: req_i && gnt_o at a rising edge. The following are latched at accept: we, be, addr, wdata, off = addr % NB, row r = addr / NB.
- Span: the access is split when any enabled lane k has off+k ≥ NB. Those lanes land in row r+1.
- Error, checked at accept:
  - any enabled byte has addr_i+k ≥ DEPTH, or
  - the access is split and ALLOW_MISALIGNED = 0.
- Error handling: the whole access is suppressed (no byte written), response err_o = 1, rdata_o = 0, single cycle.
- be_i = 0: no-op, err_o = 0, rdata_o = 0, single cycle, regardless of address.
- FSM states:
  - IDLE: accepting. On an unsplit or error access, the beat executes in the accept cycle and the FSM stays in IDLE. On a split access without error, the FSM goes to BEAT2.
  - BEAT2: gnt_o = 0. Operates on row r+1 and returns to IDLE.
- Writes: each beat writes only the enabled bytes falling in its row; other bytes are untouched.
- Reads: beat-1 bytes are held in a holding register. rdata_o is assembled from both beats and lane-rotated back so that lane k = byte addr_i+k.
- Byte index arithmetic: (off+k) mod NB selects the physical lane and carry selects the row; computed at ADDR_W+1 bits so the overflow can be detected.

## Timing
- Reset values: FSM = IDLE, gnt_o = 1, rvalid_o = 0, err_o = 0, rdata_o = 0, holding register = 0.
- Unsplit, error, or be=0 access accepted at edge T: write committed at T, rvalid_o high during cycle T+1 (latency 1).
- Split access accepted at T: row r written at T, row r+1 written at T+1, gnt_o = 0 during T+1, rvalid_o high during T+2 (latency 2).
- Back-to-back accesses: a new request may be accepted in the same cycle rvalid_o is high. A read right after a write returns the new data; there is no hazard window.
- req_i while gnt_o = 0 is ignored; the requester must hold req_i.
- rst_ni asserted mid-split: the second beat is abandoned, no rvalid_o is issued, and the row-r bytes already written stay written.
- rvalid_o is never high for two consecutive cycles from a single access.

## Test plan
- Aligned word: write 0xDEADBEEF at 0x0010 with be=4'hF, then read 0x0010 with be=4'hF → write ack rvalid at T+1 with err=0; read returns 0xDEADBEEF at T+1.
- Partial write: write 0x11223344 at 0x0020 with be=4'b0101, after 0x0020 was preloaded with 0xAAAAAAAA; read 0x0020 with be=F → 0xAA22AA44.
- Split: write 0xCAFEF00D at 0x0023 with be=F, then read 0x0020/be=F and 0x0024/be=F → 0x0DAAAAAA and 0x00CAFEF0 (0x0025-0x0027 pre-zeroed). The write's gnt_o is low for one cycle and its rvalid arrives at T+2. A read of 0x0023/be=F returns 0xCAFEF00D.
- Range: read 0x1FFE with be=F → err=1, rdata=0. Read 0x1FFE with be=4'b0011 → err=0. A write at 0x1FFE with be=F is suppressed: a later read of 0x1FFE/be=3 is unchanged.
- ALLOW_MISALIGNED=0: write at 0x0023 with be=F → err=1 at T+1, memory unchanged. Write at 0x0023 with be=4'b0001 → err=0, byte 0x23 written.
- Reset during BEAT2: rst_ni pulled low in cycle T+1 of a split write at 0x0023 → no rvalid; byte 0x23 holds the new value, bytes 0x24-0x26 keep their old values; gnt_o = 1 after reset.

Source files
------------

// File: rtl/data_mem_split_if.sv
// -----------------------------------------------------------------------------
// data_mem_split_if
// Request/response bundle between a bus master and the data_mem_split RAM.
//   req_i    master -> slave  access request, taken only while gnt_o = 1
//   we_i     master -> slave  1 = write, 0 = read
//   be_i     master -> slave  byte enables, lane k addresses byte addr_i+k
//   addr_i   master -> slave  byte start address, any alignment
//   wdata_i  master -> slave  write data, lane k goes to byte addr_i+k
//   gnt_o    slave -> master  slave ready to accept a request
//   rvalid_o slave -> master  one-cycle response strobe
//   rdata_o  slave -> master  read data, lane k = byte addr_i+k
//   err_o    slave -> master  access rejected (valid with rvalid_o)
// -----------------------------------------------------------------------------
interface data_mem_split_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_i;
  logic              we_i;
  logic [NB-1:0]     be_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic              err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/data_mem_split.sv
// -----------------------------------------------------------------------------
// data_mem_split
// Byte-addressable data RAM of 2**ADDR_W bytes organised as rows of NB bytes.
// An access whose enabled bytes cross a row boundary is executed as two row
// beats (current row in the accept cycle, next row one cycle later).
// Out-of-range accesses, and row-crossing accesses when ALLOW_MISALIGNED = 0,
// are rejected with err_o and have no effect on the memory.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset (memory contents are not reset)
//   bus     slave side of data_mem_split_if (req/gnt/rvalid handshake)
// -----------------------------------------------------------------------------
module data_mem_split #(
  parameter int ADDR_W           = 13,
  parameter int DATA_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  data_mem_split_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int ROW_W = ADDR_W - OFF_W;
  localparam int ROWS  = 2 ** ROW_W;

  typedef enum logic {IDLE, BEAT2} state_t;

  state_t            state;
  logic              we_q;
  logic [NB-1:0]     be_q;
  logic [OFF_W-1:0]  off_q;
  logic [ROW_W-1:0]  row_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] hold_q;
  logic              rvalid_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  // ---------------------------------------------------------------------------
  // Request classification on the live request (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic [NB-1:0] lane_oor;     // enabled lane beyond the last byte
  logic [NB-1:0] lane_cross;   // enabled lane that lands in the next row
  logic          range_err;
  logic          split;
  logic          acc_err;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_check
      // One extra bit on both sums so the overflow is visible.
      logic [ADDR_W:0] byte_addr;
      logic [OFF_W:0]  lane_pos;
      assign byte_addr      = {1'b0, bus.addr_i} + (ADDR_W+1)'(gi);
      assign lane_pos       = {1'b0, bus.addr_i[OFF_W-1:0]} + (OFF_W+1)'(gi);
      assign lane_oor[gi]   = bus.be_i[gi] & byte_addr[ADDR_W];
      assign lane_cross[gi] = bus.be_i[gi] & lane_pos[OFF_W];
    end
  endgenerate

  assign range_err = |lane_oor;
  assign split     = |lane_cross;
  assign acc_err   = range_err | (split & ~ALLOW_MISALIGNED);

  // ---------------------------------------------------------------------------
  // Current beat: live request in IDLE, latched request (next row) in BEAT2
  // ---------------------------------------------------------------------------
  logic              in_idle;
  logic              beat2;
  logic              exec;
  logic              cur_we;
  logic [NB-1:0]     cur_be;
  logic [OFF_W-1:0]  cur_off;
  logic [ROW_W-1:0]  cur_row;
  logic [DATA_W-1:0] cur_wdata;

  assign in_idle   = (state == IDLE);
  assign beat2     = ~in_idle;
  assign exec      = in_idle ? (bus.req_i & ~acc_err) : 1'b1;
  assign cur_we    = in_idle ? bus.we_i : we_q;
  assign cur_be    = in_idle ? bus.be_i : be_q;
  assign cur_off   = in_idle ? bus.addr_i[OFF_W-1:0] : off_q;
  assign cur_row   = in_idle ? bus.addr_i[ADDR_W-1:OFF_W] : row_q + ROW_W'(1);
  assign cur_wdata = in_idle ? bus.wdata_i : wdata_q;

  // ---------------------------------------------------------------------------
  // Physical byte lanes. Physical lane p carries logical lane (p - off) mod NB.
  // Beat 1 owns physical lanes p >= off, beat 2 owns lanes p < off.
  // ---------------------------------------------------------------------------
  logic [NB-1:0][7:0] rd_byte;

  generate
    for (gi = 0; gi < NB; gi++) begin : g_phys
      localparam logic [OFF_W-1:0] PHYS = OFF_W'(gi);

      logic [7:0]       mem [ROWS];
      logic [OFF_W-1:0] src_lane;
      logic             in_beat;
      logic             wr_en;

      assign src_lane = PHYS - cur_off;
      assign in_beat  = beat2 ? (PHYS < cur_off) : (PHYS >= cur_off);
      assign wr_en    = exec & cur_we & in_beat & cur_be[src_lane];

      always_ff @(posedge clk_i) begin
        if (wr_en) begin
          mem[cur_row] <= cur_wdata[8*src_lane +: 8];
        end
      end

      assign rd_byte[gi] = mem[cur_row];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Logical read lanes: lane k comes from physical lane (off + k) mod NB and
  // belongs to this beat only when its carry matches the beat number.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] beat_rdata;

  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [OFF_W:0] pos;
      assign pos = {1'b0, cur_off} + (OFF_W+1)'(gi);
      assign beat_rdata[8*gi +: 8] =
        (cur_be[gi] && !cur_we && (pos[OFF_W] == beat2)) ? rd_byte[pos[OFF_W-1:0]] : 8'h00;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM with registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      be_q     <= '0;
      off_q    <= '0;
      row_q    <= '0;
      wdata_q  <= '0;
      hold_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            we_q    <= bus.we_i;
            be_q    <= bus.be_i;
            off_q   <= bus.addr_i[OFF_W-1:0];
            row_q   <= bus.addr_i[ADDR_W-1:OFF_W];
            wdata_q <= bus.wdata_i;
            if (split && !acc_err) begin
              // First-row bytes wait here until the second row is read.
              hold_q <= beat_rdata;
              state  <= BEAT2;
            end else begin
              rvalid_q <= 1'b1;
              err_q    <= acc_err;
              rdata_q  <= acc_err ? '0 : beat_rdata;
            end
          end
        end
        BEAT2: begin
          rvalid_q <= 1'b1;
          err_q    <= 1'b0;
          rdata_q  <= hold_q | beat_rdata;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o    = in_idle;
  assign bus.rvalid_o = rvalid_q;
  assign bus.err_o    = err_q;
  assign bus.rdata_o  = rdata_q;
endmodule

// File: tb/tb_data_mem_split.sv
// -----------------------------------------------------------------------------
// tb_data_mem_split
// Two instances: dut_a splits row-crossing accesses, dut_b rejects them.
// Directed vectors from a table, hand-written reset/hold sequences, then
// random accesses checked against a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_data_mem_split;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8192;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  data_mem_split_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  data_mem_split_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  data_mem_split #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus_a.slave)
  );

  data_mem_split #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus_b.slave)
  );

  // Shared request fields, per-DUT request lines
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        drv_we = 1'b0;
  logic [3:0]  drv_be = 4'h0;
  logic [12:0] drv_addr = '0;
  logic [31:0] drv_wdata = '0;
  logic        cur_sel = 1'b0;

  assign bus_a.req_i   = req_a;
  assign bus_a.we_i    = drv_we;
  assign bus_a.be_i    = drv_be;
  assign bus_a.addr_i  = drv_addr;
  assign bus_a.wdata_i = drv_wdata;
  assign bus_b.req_i   = req_b;
  assign bus_b.we_i    = drv_we;
  assign bus_b.be_i    = drv_be;
  assign bus_b.addr_i  = drv_addr;
  assign bus_b.wdata_i = drv_wdata;

  logic        sel_gnt, sel_rvalid, sel_err;
  logic [31:0] sel_rdata;
  assign sel_gnt    = cur_sel ? bus_b.gnt_o    : bus_a.gnt_o;
  assign sel_rvalid = cur_sel ? bus_b.rvalid_o : bus_a.rvalid_o;
  assign sel_err    = cur_sel ? bus_b.err_o    : bus_a.err_o;
  assign sel_rdata  = cur_sel ? bus_b.rdata_o  : bus_a.rdata_o;

  int tests = 0;
  int fails = 0;

  // Reference model: one flat byte array per DUT
  logic [7:0] mem_m [2][DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Access rules on byte addresses: range check, row-crossing check, then
  // per-byte read or write of the enabled lanes.
  task automatic model_access(input bit sel, input bit we, input logic [3:0] be,
                              input logic [12:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er, output int lat);
    bit rng = 0;
    bit crs = 0;
    rd = '0;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        if (int'(addr) + k >= DEPTH) rng = 1;
        if ((int'(addr) % 4) + k >= 4) crs = 1;
      end
    end
    er  = rng || (crs && sel);   // sel = 1 is the instance without split support
    lat = (crs && !er) ? 2 : 1;
    if (!er) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          if (we) mem_m[sel][int'(addr) + k] = wd[8*k +: 8];
          else    rd[8*k +: 8] = mem_m[sel][int'(addr) + k];
        end
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge inside the rvalid cycle.
  task automatic drive(input bit sel, input bit we, input logic [3:0] be,
                       input logic [12:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic gnt_low);
    int waited = 0;
    cur_sel   = sel;
    drv_we    = we;
    drv_be    = be;
    drv_addr  = addr;
    drv_wdata = wd;
    rd = '0; er = 1'b0; lat = -1; gnt_low = 1'b0;
    #1;
    while (!sel_gnt && waited < 8) begin
      @(negedge clk_i);
      waited++;
    end
    if (!sel_gnt) begin
      tests++; fails++;
      $display("FAIL gnt_timeout: got gnt=0, expected gnt=1 within 8 cycles");
      return;
    end
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk_i);
    #1;
    req_a = 1'b0;
    req_b = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      if (c == 1) gnt_low = !sel_gnt;
      if (sel_rvalid) begin
        lat = c;
        rd  = sel_rdata;
        er  = sel_err;
        break;
      end
    end
    $display("[TB] txn dut=%0d we=%0d be=%h addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             sel, we, be, addr, wd, rd, er, lat);
  endtask

  task automatic run_checked(input bit sel, input bit we, input logic [3:0] be,
                             input logic [12:0] addr, input logic [31:0] wd,
                             input string tag);
    logic [31:0] rd, erd;
    logic er, eer, gl;
    int lat, elat;
    drive(sel, we, be, addr, wd, rd, er, lat, gl);
    model_access(sel, we, be, addr, wd, erd, eer, elat);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_err"}, {31'b0, er}, {31'b0, eer});
    check({tag, "_lat"}, lat, elat);
  endtask

  typedef struct {
    bit          sel;
    bit          we;
    logic [3:0]  be;
    logic [12:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit sel, input bit we, input logic [3:0] be, input logic [12:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err,
                     input int exp_lat);
    vec_t v;
    v.sel = sel; v.we = we; v.be = be; v.addr = addr; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, erd;
    logic er, eer, gl;
    int lat, elat;

    // ---------------- reset values ----------------
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_gnt_a",    {31'b0, bus_a.gnt_o},    32'd1);
    check("rst_rvalid_a", {31'b0, bus_a.rvalid_o}, 32'd0);
    check("rst_err_a",    {31'b0, bus_a.err_o},    32'd0);
    check("rst_rdata_a",  bus_a.rdata_o,           32'd0);
    check("rst_gnt_b",    {31'b0, bus_b.gnt_o},    32'd1);
    check("rst_rdata_b",  bus_b.rdata_o,           32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // ---------------- zero the regions used below ----------------
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 256; a += 4)
        run_checked(s[0], 1'b1, 4'hF, 13'(a), 32'h0, "init_lo");
      for (int a = 'h1F00; a < DEPTH; a += 4)
        run_checked(s[0], 1'b1, 4'hF, 13'(a), 32'h0, "init_hi");
    end

    // ---------------- directed vectors ----------------
    //   sel we be     addr      wdata         exp_rdata     err lat
    add(0, 1, 4'hF, 13'h0010, 32'hDEADBEEF, 32'h00000000, 0, 1);
    add(0, 0, 4'hF, 13'h0010, 32'h0,        32'hDEADBEEF, 0, 1);
    add(0, 1, 4'hF, 13'h0020, 32'hAAAAAAAA, 32'h00000000, 0, 1);
    add(0, 1, 4'h5, 13'h0020, 32'h11223344, 32'h00000000, 0, 1);
    add(0, 0, 4'hF, 13'h0020, 32'h0,        32'hAA22AA44, 0, 1);
    add(0, 1, 4'hF, 13'h0020, 32'hAAAAAAAA, 32'h00000000, 0, 1);
    add(0, 1, 4'hF, 13'h0023, 32'hCAFEF00D, 32'h00000000, 0, 2);
    add(0, 0, 4'hF, 13'h0020, 32'h0,        32'h0DAAAAAA, 0, 1);
    add(0, 0, 4'hF, 13'h0024, 32'h0,        32'h00CAFEF0, 0, 1);
    add(0, 0, 4'hF, 13'h0023, 32'h0,        32'hCAFEF00D, 0, 2);
    add(0, 1, 4'hF, 13'h1FFC, 32'h5A6B7C8D, 32'h00000000, 0, 1);
    add(0, 0, 4'hF, 13'h1FFE, 32'h0,        32'h00000000, 1, 1);
    add(0, 0, 4'h3, 13'h1FFE, 32'h0,        32'h00005A6B, 0, 1);
    add(0, 1, 4'hF, 13'h1FFE, 32'h12345678, 32'h00000000, 1, 1);
    add(0, 0, 4'h3, 13'h1FFE, 32'h0,        32'h00005A6B, 0, 1);
    add(1, 1, 4'hF, 13'h0023, 32'h99887766, 32'h00000000, 1, 1);
    add(1, 0, 4'hF, 13'h0020, 32'h0,        32'h00000000, 0, 1);
    add(1, 1, 4'h1, 13'h0023, 32'h000000EE, 32'h00000000, 0, 1);
    add(1, 0, 4'hF, 13'h0020, 32'h0,        32'hEE000000, 0, 1);
    add(1, 0, 4'hF, 13'h0023, 32'h0,        32'h00000000, 1, 1);
    add(0, 1, 4'h0, 13'h1FFD, 32'hFFFFFFFF, 32'h00000000, 0, 1);
    add(0, 0, 4'hA, 13'h0021, 32'h0,        32'hF000AA00, 0, 2);

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, rd, er, lat, gl);
      model_access(vecs[i].sel, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, erd, eer, elat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_gnt_low", i), {31'b0, gl}, {31'b0, (vecs[i].exp_lat == 2)});
    end

    // ---------------- rdata held, single rvalid pulse ----------------
    drive(0, 1'b0, 4'hF, 13'h0010, 32'h0, rd, er, lat, gl);
    check("hold_first", rd, 32'hDEADBEEF);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check($sformatf("hold_rdata_%0d", c), bus_a.rdata_o, 32'hDEADBEEF);
      check($sformatf("hold_rvalid_%0d", c), {31'b0, bus_a.rvalid_o}, 32'd0);
    end

    // ---------------- reset during the second beat ----------------
    run_checked(0, 1'b1, 4'hF, 13'h0020, 32'h44332211, "pre_rst0");
    run_checked(0, 1'b1, 4'hF, 13'h0024, 32'h88776655, "pre_rst1");
    cur_sel   = 1'b0;
    drv_we    = 1'b1;
    drv_be    = 4'hF;
    drv_addr  = 13'h0023;
    drv_wdata = 32'hF1E2D3C4;
    req_a     = 1'b1;
    @(posedge clk_i);
    #1;
    req_a = 1'b0;
    @(negedge clk_i);
    check("rst_mid_gnt_low", {31'b0, bus_a.gnt_o}, 32'd0);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_gnt_async", {31'b0, bus_a.gnt_o}, 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rst_mid_no_rvalid_%0d", c), {31'b0, bus_a.rvalid_o}, 32'd0);
      check($sformatf("rst_mid_gnt_%0d", c), {31'b0, bus_a.gnt_o}, 32'd1);
      @(negedge clk_i);
    end
    mem_m[0][13'h0023] = 8'hC4;   // only the first-row byte landed
    drive(0, 1'b0, 4'hF, 13'h0020, 32'h0, rd, er, lat, gl);
    check("rst_mid_row0", rd, 32'hC4332211);
    drive(0, 1'b0, 4'hF, 13'h0024, 32'h0, rd, er, lat, gl);
    check("rst_mid_row1", rd, 32'h88776655);

    // ---------------- random accesses vs model ----------------
    for (int n = 0; n < 400; n++) begin
      bit          s  = 1'($urandom_range(0, 1));
      bit          w  = 1'($urandom_range(0, 1));
      logic [3:0]  b  = 4'($urandom_range(0, 15));
      logic [12:0] a;
      logic [31:0] d  = $urandom;
      if ($urandom_range(0, 1) == 0) a = 13'($urandom_range(0, 252));
      else                           a = 13'h1FF0 + 13'($urandom_range(0, 15));
      run_checked(s, w, b, a, d, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
